// File: rtl/des_key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_key_pkg
// Description : Shared constants and types for the DES key rotator. Holds
//               the PC-1 selection table, the per-round shift schedule, the
//               C/D half width, the round count and the FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package des_key_pkg;

  // Number of CD values emitted per key (fixed by DES)
  localparam int c_rounds = 16;

  // Width of each of the C and D halves, and of the joined CD value
  localparam int c_half_w = 28;
  localparam int c_cd_w   = 2 * c_half_w;
  localparam int c_key_w  = 64;

  // PC-1: entry k gives the 1-based key bit number that lands in CD bit k+1.
  // Entries 0..27 build C, entries 28..55 build D.
  localparam int unsigned c_pc1_table [0:c_cd_w-1] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Shift amount for round r is entry r-1; the amounts sum to one full
  // revolution of a 28-bit half, so CD16 equals CD0.
  localparam logic [1:0] c_shift_sched [0:c_rounds-1] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Sequencer states: waiting for a key, or streaming its round values
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True when the schedule entry at idx (round idx+1) calls for a 2-bit shift
  function automatic logic sched_is_two(input logic [3:0] idx);
    return (c_shift_sched[idx] == 2'd2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_cd_rotate.sv
`default_nettype none
// ============================================================================
// Module      : des_cd_rotate
// Description : Combinational rotate of one 28-bit DES key half by 1 or 2
//               places. Index form: left gives new[i] = old[(i+s) mod 28]
//               (standard bit 1 moves to bit 28); right is its inverse.
// Revision    : 1.0 - initial release
// ============================================================================
module des_cd_rotate
  import des_key_pkg::*;
(
  input  logic [c_half_w-1:0] i_din,
  input  logic                i_two,
  input  logic                i_right,
  output logic [c_half_w-1:0] o_dout
);

  // Select one of the four rotations by direction and distance
  always_comb begin
    o_dout = i_din;
    case ({i_right, i_two})
      2'b00:   o_dout = {i_din[0],            i_din[c_half_w-1:1]};
      2'b01:   o_dout = {i_din[1:0],          i_din[c_half_w-1:2]};
      2'b10:   o_dout = {i_din[c_half_w-2:0], i_din[c_half_w-1]};
      2'b11:   o_dout = {i_din[c_half_w-3:0], i_din[c_half_w-1:c_half_w-2]};
      default: o_dout = i_din;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/des_key_rotator.sv
`default_nettype none
// ============================================================================
// Module      : des_key_rotator
// Description : Accepts a 64-bit DES key, applies PC-1 and streams the 16
//               per-round 56-bit CD values (encrypt order CD1..CD16 or
//               decrypt order CD16..CD1) over a valid/ready handshake, in
//               the bit order expected by the PC-2 stage.
// Options     : DES_KEY_PARITY_CHECK_EN - when defined, each key byte is
//               checked for odd parity at load and parity_err reports any
//               failing byte; when undefined parity_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module des_key_rotator
  import des_key_pkg::*;
#(
  parameter int ROUNDS = c_rounds
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [c_key_w-1:0] key_in,
  input  logic               key_decrypt,
  input  logic               key_valid,
  output logic               key_ready,
  output logic [c_cd_w-1:0]  cd_out,
  output logic [3:0]         cd_round,
  output logic               cd_valid,
  input  logic               cd_ready,
  output logic               parity_err
);

  localparam logic [3:0] c_last_round = 4'(ROUNDS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_half_w-1:0] r_c;
  logic [c_half_w-1:0] r_d;
  logic [3:0]          r_round;
  logic                r_decrypt;

  logic [c_cd_w-1:0]   w_pc1;
  logic [c_half_w-1:0] w_rot_c_in;
  logic [c_half_w-1:0] w_rot_d_in;
  logic [c_half_w-1:0] w_rot_c_out;
  logic [c_half_w-1:0] w_rot_d_out;
  logic [3:0]          w_sched_idx;
  logic                w_rot_two;
  logic                w_rot_right;
  logic                w_load;
  logic                w_advance;

  // PC-1: standard key bit b sits at key_in[64-b]
  for (genvar k = 0; k < c_cd_w; k++) begin : g_pc1
    localparam int c_src = c_key_w - int'(c_pc1_table[k]);
    assign w_pc1[k] = key_in[c_src];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake outputs and load/advance strobes
  always_comb begin
    w_state_nxt = r_state;
    key_ready   = 1'b0;
    cd_valid    = 1'b0;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        key_ready = 1'b1;
        w_load    = key_valid;
        if (key_valid) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        cd_valid  = 1'b1;
        w_advance = cd_ready;
        if (cd_ready && (r_round == c_last_round)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Rotator operands: PC-1 output on load (first encrypt step), the held
  // CD value while running. Decrypt walks the schedule backwards, undoing
  // the shift of the round currently on the output.
  always_comb begin
    w_rot_c_in  = w_pc1[c_half_w-1:0];
    w_rot_d_in  = w_pc1[c_cd_w-1:c_half_w];
    w_sched_idx = 4'd0;
    w_rot_right = 1'b0;
    if (r_state == RUN) begin
      w_rot_c_in  = r_c;
      w_rot_d_in  = r_d;
      w_rot_right = r_decrypt;
      w_sched_idx = r_decrypt ? (c_last_round - r_round) : (r_round + 4'd1);
    end
    w_rot_two = sched_is_two(w_sched_idx);
  end

  des_cd_rotate u_rot_c (
    .i_din   (w_rot_c_in),
    .i_two   (w_rot_two),
    .i_right (w_rot_right),
    .o_dout  (w_rot_c_out)
  );

  des_cd_rotate u_rot_d (
    .i_din   (w_rot_d_in),
    .i_two   (w_rot_two),
    .i_right (w_rot_right),
    .o_dout  (w_rot_d_out)
  );

  // CD value, round counter and mode: decrypt starts at CD16 = CD0, so the
  // PC-1 output is taken unrotated; the counter returns to 0 on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c       <= '0;
      r_d       <= '0;
      r_round   <= 4'd0;
      r_decrypt <= 1'b0;
    end else if (w_load) begin
      r_c       <= key_decrypt ? w_pc1[c_half_w-1:0]        : w_rot_c_out;
      r_d       <= key_decrypt ? w_pc1[c_cd_w-1:c_half_w]   : w_rot_d_out;
      r_round   <= 4'd0;
      r_decrypt <= key_decrypt;
    end else if (w_advance) begin
      r_c       <= w_rot_c_out;
      r_d       <= w_rot_d_out;
      r_round   <= (r_round == c_last_round) ? 4'd0 : (r_round + 4'd1);
    end
  end

  assign cd_out   = {r_d, r_c};
  assign cd_round = r_round;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic [7:0] w_byte_bad;
  logic       r_parity_err;

  // A byte fails when its ones count is even
  for (genvar b = 0; b < 8; b++) begin : g_parity
    assign w_byte_bad[b] = ~(^key_in[8*b +: 8]);
  end

  // Parity flag captured at load, held until the next load or reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (w_load) begin
      r_parity_err <= |w_byte_bad;
    end
  end

  assign parity_err = r_parity_err;
`else
  // PC-1 drops the eight parity bits; they are only consumed by the check
  logic w_unused_parity_bits;
  assign w_unused_parity_bits = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                  key_in[24], key_in[16], key_in[8],  key_in[0]};
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_des_key_rotator.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_key_rotator
// Description : Self-checking bench for des_key_rotator: known-answer table,
//               back-pressure, ignored mid-run keys, async reset and random
//               keys against a behavioural model of the DES key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_key_rotator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] key_in = '0;
  logic        key_decrypt = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [55:0] cd_out;
  logic [3:0]  cd_round;
  logic        cd_valid;
  logic        cd_ready = 1'b1;
  logic        parity_err;

  int n_checks = 0;
  int n_errors = 0;

  localparam int c_pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int c_shift [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [55:0] cap_cd  [16];
  logic        cap_par [16];

  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          beat;
    logic        chk_cd;
    logic [27:0] c_lit;   // written bit 1 first (leftmost)
    logic [27:0] d_lit;
    logic        par_en;  // expected parity_err when the check is built in
  } vec_t;

  vec_t vecs [8];

  des_key_rotator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_decrypt (key_decrypt),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .cd_out      (cd_out),
    .cd_round    (cd_round),
    .cd_valid    (cd_valid),
    .cd_ready    (cd_ready),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // CD_r: PC-1 of the key, each half rotated left by the summed schedule
  function automatic logic [55:0] model_cd(input logic [63:0] key, input int r);
    logic [27:0] c0;
    logic [27:0] d0;
    logic [55:0] res;
    int tot = 0;
    for (int i = 0; i < 28; i++) begin
      c0[i] = key[64 - c_pc1[i]];
      d0[i] = key[64 - c_pc1[28 + i]];
    end
    for (int j = 1; j <= r; j++) tot += c_shift[j-1];
    for (int i = 0; i < 28; i++) begin
      res[i]      = c0[(i + tot) % 28];
      res[28 + i] = d0[(i + tot) % 28];
    end
    return res;
  endfunction

  function automatic logic [55:0] model_beat(input logic [63:0] key, input logic dec, input int k);
    return dec ? model_cd(key, 16 - k) : model_cd(key, k + 1);
  endfunction

  function automatic logic model_par(input logic [63:0] key);
    logic bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(key[8*b + i]);
      if (ones % 2 == 0) bad = 1'b1;
    end
`ifdef DES_KEY_PARITY_CHECK_EN
    return bad;
`else
    return 1'b0 & bad;
`endif
  endfunction

  function automatic logic [27:0] rev28(input logic [27:0] v);
    logic [27:0] r;
    for (int i = 0; i < 28; i++) r[i] = v[27 - i];
    return r;
  endfunction

  // Load one key and collect all 16 beats, checking each against the model.
  // stall_round/stall_cycles hold cd_ready low at one round; intrude offers a
  // different key throughout the run; rnd adds random back-pressure.
  task automatic run_key(input logic [63:0] key, input logic dec, input int stall_round,
                         input int stall_cycles, input bit intrude, input bit rnd);
    int          nbeats = 0;
    int          cycles = 0;
    int          stall_cnt = 0;
    bit          pending = 1'b0;
    bit          ready;
    logic [55:0] prev_cd = '0;
    logic [3:0]  prev_round = '0;
    logic        exp_par = model_par(key);
    @(negedge clk);
    check("idle_flags", 64'({key_ready, cd_valid}), 64'd2);
    key_in      = key;
    key_decrypt = dec;
    key_valid   = 1'b1;
    cd_ready    = 1'b1;
    @(negedge clk);
    if (intrude) begin
      key_in      = ~key;
      key_decrypt = ~dec;
      key_valid   = 1'b1;
    end else begin
      key_valid   = 1'b0;
    end
    while (nbeats < 16 && cycles < 200) begin
      check("run_flags", 64'({key_ready, cd_valid}), 64'd1);
      if (pending) begin
        check("hold_cd", 64'(cd_out), 64'(prev_cd));
        check("hold_round", 64'(cd_round), 64'(prev_round));
      end
      ready = 1'b1;
      if (int'(cd_round) == stall_round && stall_cnt < stall_cycles) begin
        ready = 1'b0;
        stall_cnt++;
      end else if (rnd && $urandom_range(0, 3) == 0) begin
        ready = 1'b0;
      end
      cd_ready = ready;
      if (ready) begin
        check("beat_round", 64'(cd_round), 64'(nbeats));
        check("beat_cd", 64'(cd_out), 64'(model_beat(key, dec, nbeats)));
        check("beat_par", 64'(parity_err), 64'(exp_par));
        cap_cd[nbeats]  = cd_out;
        cap_par[nbeats] = parity_err;
        nbeats++;
        pending = 1'b0;
      end else begin
        pending    = 1'b1;
        prev_cd    = cd_out;
        prev_round = cd_round;
      end
      @(negedge clk);
      cycles++;
    end
    key_valid = 1'b0;
    cd_ready  = 1'b1;
    check("beats_done", 64'(nbeats), 64'd16);
    check("done_flags", 64'({key_ready, cd_valid}), 64'd2);
    check("done_par", 64'(parity_err), 64'(exp_par));
    if (!rnd) check("cycle_count", 64'(cycles), 64'(16 + stall_cycles));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rkey;
    logic        rdec;
    logic        exp_par;
    int          guard;

    vecs[0] = '{64'h133457799BBCDFF1, 1'b0, 0,  1'b1,
                28'b1110000110011001010101011111, 28'b1010101011001100111100011110, 1'b0};
    vecs[1] = '{64'h133457799BBCDFF1, 1'b0, 1,  1'b1,
                28'b1100001100110010101010111111, 28'b0101010110011001111000111101, 1'b0};
    vecs[2] = '{64'h133457799BBCDFF1, 1'b0, 15, 1'b1,
                28'b1111000011001100101010101111, 28'b0101010101100110011110001111, 1'b0};
    vecs[3] = '{64'h133457799BBCDFF1, 1'b1, 0,  1'b1,
                28'b1111000011001100101010101111, 28'b0101010101100110011110001111, 1'b0};
    vecs[4] = '{64'h133457799BBCDFF1, 1'b1, 14, 1'b1,
                28'b1100001100110010101010111111, 28'b0101010110011001111000111101, 1'b0};
    vecs[5] = '{64'h133457799BBCDFF1, 1'b1, 15, 1'b1,
                28'b1110000110011001010101011111, 28'b1010101011001100111100011110, 1'b0};
    vecs[6] = '{64'h0101010101010101, 1'b0, 0,  1'b0, 28'd0, 28'd0, 1'b0};
    vecs[7] = '{64'h0001010101010101, 1'b1, 0,  1'b0, 28'd0, 28'd0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_key_ready", 64'(key_ready), 64'd1);
    check("rst_cd_valid", 64'(cd_valid), 64'd0);
    check("rst_cd_out", 64'(cd_out), 64'd0);
    check("rst_cd_round", 64'(cd_round), 64'd0);
    check("rst_parity", 64'(parity_err), 64'd0);
    rst_n = 1'b1;

    // Known-answer table
    for (int v = 0; v < 8; v++) begin
      run_key(vecs[v].key, vecs[v].dec, -1, 0, 1'b0, 1'b0);
      if (vecs[v].chk_cd) begin
        check("tbl_cd", 64'(cap_cd[vecs[v].beat]),
              64'({rev28(vecs[v].d_lit), rev28(vecs[v].c_lit)}));
      end
`ifdef DES_KEY_PARITY_CHECK_EN
      exp_par = vecs[v].par_en;
`else
      exp_par = 1'b0;
`endif
      check("tbl_par_first", 64'(cap_par[0]), 64'(exp_par));
      check("tbl_par_last", 64'(cap_par[15]), 64'(exp_par));
    end

    // Back-pressure: 5 stalled cycles at round 3
    run_key(64'h133457799BBCDFF1, 1'b0, 3, 5, 1'b0, 1'b0);

    // Different key offered during the run is ignored
    run_key(64'h133457799BBCDFF1, 1'b1, -1, 0, 1'b1, 1'b0);

    // Asynchronous reset at round 7, then a fresh key restarts at round 0
    @(negedge clk);
    key_in      = 64'h0001010101010101;
    key_decrypt = 1'b0;
    key_valid   = 1'b1;
    cd_ready    = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    guard = 0;
    while (cd_round != 4'd7 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("mid_reach_r7", 64'(cd_round), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cd_valid", 64'(cd_valid), 64'd0);
    check("mid_rst_key_ready", 64'(key_ready), 64'd1);
    check("mid_rst_cd_out", 64'(cd_out), 64'd0);
    check("mid_rst_cd_round", 64'(cd_round), 64'd0);
    check("mid_rst_parity", 64'(parity_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_key(64'h133457799BBCDFF1, 1'b0, -1, 0, 1'b0, 1'b0);

    // Random keys, modes and back-pressure
    for (int n = 0; n < 12; n++) begin
      rkey = {$urandom(), $urandom()};
      rdec = 1'($urandom_range(0, 1));
      run_key(rkey, rdec, $urandom_range(0, 15), $urandom_range(0, 4),
              1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
